// File: rtl/ram_port_queue.sv
// Per-port Wishbone request queue in front of the dual-bank RAM arbiter.
// Optional same-cycle bypass of an empty, idle queue: define RAM_PORT_QUEUE_BYPASS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 14
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ram_port_queue #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_stb_i,
    input  logic [3:0]             m_we_i,
    input  logic [`ADDR_WIDTH-1:0] m_addr_i,
    input  logic [`DATA_WIDTH-1:0] m_data_i,
    output logic                   m_stall_o,
    output logic                   m_ack_o,
    output logic [`DATA_WIDTH-1:0] m_data_o,
    output logic                   wb_stb_o,
    output logic [3:0]             wb_we_o,
    output logic [`ADDR_WIDTH-1:0] wb_addr_o,
    output logic [`DATA_WIDTH-1:0] wb_data_o,
    input  logic                   wb_stall_i,
    input  logic                   wb_ack_i,
    input  logic [`DATA_WIDTH-1:0] wb_data_i
);

    localparam int AW    = `ADDR_WIDTH;
    localparam int DW    = `DATA_WIDTH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        outstanding_q, outstanding_d;
    logic              last_bank_q, last_bank_d;
    logic [AW-1:0]     last_addr_q, last_addr_d;
    logic              m_ack_q, m_ack_d;
    logic [DW-1:0]     m_data_q, m_data_d;

    entry_t            m_entry;
    entry_t            head;
    entry_t            issue_entry;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_ok;
    logic              bypass;
    logic              wb_stb;
    logic              issue;
    logic              push;
    logic              pop;
    logic              ack_ok;

    always_comb begin
        m_entry    = '{we: m_we_i, addr: m_addr_i, data: m_data_i};
        head       = mem_q[rd_ptr_q];
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        // A new bank may only be issued once every read on the old bank has returned.
        head_ok    = !fifo_empty
                     && (outstanding_q < 2'(MAX_OUTSTANDING))
                     && ((outstanding_q == '0) || (head.addr[AW-1] == last_bank_q));
`ifdef RAM_PORT_QUEUE_BYPASS_EN
        bypass     = fifo_empty && (outstanding_q == '0) && m_stb_i;
`else
        bypass     = 1'b0;
`endif
        wb_stb      = head_ok || bypass;
        issue_entry = bypass ? m_entry : head;
        issue       = wb_stb && !wb_stall_i;
        pop         = issue && !bypass;
        push        = m_stb_i && !fifo_full && !(bypass && issue);
        ack_ok      = wb_ack_i && (outstanding_q != '0);
    end

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        outstanding_d = outstanding_q;
        if (issue && !ack_ok) outstanding_d = outstanding_q + 1'b1;
        if (ack_ok && !issue) outstanding_d = outstanding_q - 1'b1;
        last_bank_d   = issue ? issue_entry.addr[AW-1] : last_bank_q;
        last_addr_d   = issue ? issue_entry.addr : last_addr_q;
        m_ack_d       = ack_ok;
        m_data_d      = ack_ok ? wb_data_i : m_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= m_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            last_bank_q   <= 1'b0;
            last_addr_q   <= '0;
            m_ack_q       <= 1'b0;
            m_data_q      <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            last_bank_q   <= last_bank_d;
            last_addr_q   <= last_addr_d;
            m_ack_q       <= m_ack_d;
            m_data_q      <= m_data_d;
        end
    end

    // Idle address parks on the last issued bank so the arbiter read mux stays put.
    assign wb_stb_o  = wb_stb;
    assign wb_we_o   = wb_stb ? issue_entry.we   : 4'b0;
    assign wb_addr_o = wb_stb ? issue_entry.addr : last_addr_q;
    assign wb_data_o = wb_stb ? issue_entry.data : '0;
    assign m_stall_o = fifo_full;
    assign m_ack_o   = m_ack_q;
    assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_ram_port_queue.sv
// Directed self-checking bench for ram_port_queue with a fixed-latency arbiter model.
// Expected cycle numbers shift by one when RAM_PORT_QUEUE_BYPASS_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 14
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_ram_port_queue;

    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
`ifdef RAM_PORT_QUEUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m_stb_i;
    logic [3:0]    m_we_i;
    logic [AW-1:0] m_addr_i;
    logic [DW-1:0] m_data_i;
    logic          m_stall_o;
    logic          m_ack_o;
    logic [DW-1:0] m_data_o;
    logic          wb_stb_o;
    logic [3:0]    wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic          wb_stall_i;
    logic          wb_ack_i;
    logic [DW-1:0] wb_data_i;

    int            checks = 0;
    int            errors = 0;
    int            ack_cnt;
    int            tb_out;
    logic          ack_en;
    logic          force_ack;
    logic [AW-1:0] issue_log [$];

    ram_port_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
        .m_stall_o(m_stall_o), .m_ack_o(m_ack_o), .m_data_o(m_data_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_data_i(wb_data_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] respData(input logic [AW-1:0] a);
        return (a == AW'(16)) ? 32'hDEADBEEF : (32'h5A000000 | DW'(a));
    endfunction

    // Arbiter model: an issue seen in cycle n is acked in cycle n+2.
    initial begin : arbiter
        logic          issued, p1, p2;
        logic [AW-1:0] p1_addr, p2_addr;
        p1 = 1'b0; p2 = 1'b0; p1_addr = '0; p2_addr = '0;
        ack_cnt = 0; tb_out = 0; wb_ack_i = 1'b0; wb_data_i = '0;
        forever begin
            @(negedge clk_i); #3;
            if (m_ack_o) ack_cnt++;
            if (rst_i) begin
                p1 = 1'b0; p2 = 1'b0; tb_out = 0; wb_ack_i = 1'b0;
            end else begin
                issued    = wb_stb_o && !wb_stall_i;
                wb_ack_i  = (ack_en && p2) || force_ack;
                wb_data_i = respData(p2_addr);
                if (wb_ack_i && tb_out > 0) tb_out--;
                if (issued) begin
                    tb_out++;
                    issue_log.push_back(wb_addr_o);
                end
                p2 = p1; p2_addr = p1_addr;
                p1 = issued; p1_addr = wb_addr_o;
            end
        end
    end

    task automatic nextCycle();
        @(negedge clk_i); #1;
    endtask

    task automatic applyStimulus(input logic stb, input logic [3:0] we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        m_stb_i = stb; m_we_i = we; m_addr_i = addr; m_data_i = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin : stimulus
        int            stb_cyc, ack_cyc, base_ack, base_iss, idx, held, max_out;
        logic [AW-1:0] stb_addr;
        logic [DW-1:0] ack_data;
        logic          acc;
        logic          stb_at [0:7];
        logic [AW-1:0] addr_at [0:7];

        rst_i = 1'b1; wb_stall_i = 1'b0; ack_en = 1'b1; force_ack = 1'b0;
        applyStimulus(1'b0, 4'h0, '0, '0);
        nextCycle(); nextCycle();
        checkOutput("rst_m_stall", 32'(m_stall_o), 0);
        checkOutput("rst_m_ack", 32'(m_ack_o), 0);
        checkOutput("rst_m_data", m_data_o, 0);
        checkOutput("rst_wb_stb", 32'(wb_stb_o), 0);
        checkOutput("rst_wb_we", 32'(wb_we_o), 0);
        checkOutput("rst_wb_addr", 32'(wb_addr_o), 0);
        checkOutput("rst_wb_data", wb_data_o, 0);
        rst_i = 1'b0;

        // Single read
        nextCycle();
        base_ack = ack_cnt; stb_cyc = -1; ack_cyc = -1; stb_addr = '0; ack_data = '0;
        applyStimulus(1'b1, 4'h0, AW'(16'h0010), '0);
        #1;
        if (wb_stb_o) begin stb_cyc = 0; stb_addr = wb_addr_o; end
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            if (wb_stb_o && stb_cyc < 0) begin stb_cyc = k; stb_addr = wb_addr_o; end
            if (m_ack_o && ack_cyc < 0) begin ack_cyc = k; ack_data = m_data_o; end
            if (k == 1) applyStimulus(1'b0, 4'h0, '0, '0);
        end
        nextCycle();
        checkOutput("read_stb_cycle", stb_cyc, 1 - BYP);
        checkOutput("read_stb_addr", 32'(stb_addr), 32'h0010);
        checkOutput("read_ack_cycle", ack_cyc, 4 - BYP);
        checkOutput("read_ack_data", ack_data, 32'hDEADBEEF);
        checkOutput("read_ack_count", ack_cnt - base_ack, 1);

        // Burst and fill with the arbiter stalled
        wb_stall_i = 1'b1; base_ack = ack_cnt; base_iss = issue_log.size();
        idx = 0; held = 0; max_out = 0;
        applyStimulus(1'b1, 4'hF, AW'(256), DW'(4096));
        for (int k = 0; k < 80 && (ack_cnt - base_ack) < 6; k++) begin
            acc = m_stb_i && !m_stall_o;
            nextCycle();
            if (acc) begin
                idx++;
                if (idx == 3) checkOutput("burst_stall_after3", 32'(m_stall_o), 0);
                if (idx == 4) checkOutput("burst_stall_after4", 32'(m_stall_o), 1);
            end
            if (idx < 6) applyStimulus(1'b1, 4'hF, AW'(256 + idx), DW'(4096 + idx));
            else applyStimulus(1'b0, 4'h0, '0, '0);
            if (idx == 4 && wb_stall_i) begin
                held++;
                if (held == 2) begin
                    checkOutput("stalled_wb_stb", 32'(wb_stb_o), 1);
                    checkOutput("stalled_wb_addr", 32'(wb_addr_o), 32'h0100);
                    checkOutput("stalled_wb_we", 32'(wb_we_o), 32'hF);
                    checkOutput("stalled_wb_data", wb_data_o, 32'h1000);
                end
                if (held == 3) wb_stall_i = 1'b0;
            end
            if (int'(dut.outstanding_q) > max_out) max_out = int'(dut.outstanding_q);
        end
        checkOutput("burst_ack_count", ack_cnt - base_ack, 6);
        checkOutput("burst_issue_count", issue_log.size() - base_iss, 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("burst_issue%0d", i),
                        (base_iss + i < issue_log.size()) ? 32'(issue_log[base_iss + i]) : 32'hFFFF_FFFF,
                        256 + i);
        checkOutput("burst_max_outstanding", max_out, 2);
        nextCycle(); nextCycle();

        // Bank switch
        nextCycle();
        applyStimulus(1'b1, 4'h0, AW'(16'h0004), '0);
        #1;
        stb_at[0] = wb_stb_o; addr_at[0] = wb_addr_o;
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            stb_at[k] = wb_stb_o; addr_at[k] = wb_addr_o;
            if (k == 1) applyStimulus(1'b1, 4'h0, AW'(16'h2004), '0);
            if (k == 2) applyStimulus(1'b0, 4'h0, '0, '0);
        end
        checkOutput("bank_first_stb", 32'(stb_at[1 - BYP]), 1);
        checkOutput("bank_first_addr", 32'(addr_at[1 - BYP]), 32'h0004);
        checkOutput("bank_hold_stb_a", 32'(stb_at[2 - BYP]), 0);
        checkOutput("bank_hold_addr_a", 32'(addr_at[2 - BYP]), 32'h0004);
        checkOutput("bank_hold_stb_b", 32'(stb_at[3 - BYP]), 0);
        checkOutput("bank_hold_addr_b", 32'(addr_at[3 - BYP]), 32'h0004);
        checkOutput("bank_second_stb", 32'(stb_at[4 - BYP]), 1);
        checkOutput("bank_second_addr", 32'(addr_at[4 - BYP]), 32'h2004);
        nextCycle(); nextCycle();

        // Spurious ack while idle
        base_ack = ack_cnt;
        force_ack = 1'b1;
        nextCycle();
        force_ack = 1'b0;
        checkOutput("spur_m_ack", 32'(m_ack_o), 0);
        checkOutput("spur_outstanding", 32'(dut.outstanding_q), 0);
        nextCycle();
        checkOutput("spur_ack_count", ack_cnt - base_ack, 0);

        // Issue and ack in the same cycle
        nextCycle();
        base_ack = ack_cnt;
        applyStimulus(1'b1, 4'h0, AW'(16'h0020), '0);
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            if (k == 3 - BYP) begin
                checkOutput("overlap_wb_stb", 32'(wb_stb_o), 1);
                checkOutput("overlap_wb_addr", 32'(wb_addr_o), 32'h0024);
            end
            if (k == 4 - BYP) checkOutput("overlap_outstanding", 32'(dut.outstanding_q), 1);
            if (k == 1) applyStimulus(1'b0, 4'h0, '0, '0);
            if (k == 2 - BYP) applyStimulus(1'b1, 4'h0, AW'(16'h0024), '0);
            if (k == 3 - BYP) applyStimulus(1'b0, 4'h0, '0, '0);
        end
        nextCycle();
        checkOutput("overlap_ack_count", ack_cnt - base_ack, 2);

        // Reset with 3 queued and 2 outstanding; acks withheld until after reset
        ack_en = 1'b0;
        nextCycle();
        applyStimulus(1'b1, 4'h0, AW'(16'h0300), '0);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            applyStimulus(1'b1, 4'h0, AW'(16'h0300 + k), '0);
        end
        nextCycle();
        applyStimulus(1'b0, 4'h0, '0, '0);
        checkOutput("pre_rst_outstanding", 32'(dut.outstanding_q), 2);
        checkOutput("pre_rst_count", 32'(dut.count_q), 3);
        checkOutput("pre_rst_wb_stb", 32'(wb_stb_o), 0);
        rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        checkOutput("mid_rst_m_stall", 32'(m_stall_o), 0);
        checkOutput("mid_rst_m_ack", 32'(m_ack_o), 0);
        checkOutput("mid_rst_m_data", m_data_o, 0);
        checkOutput("mid_rst_wb_stb", 32'(wb_stb_o), 0);
        checkOutput("mid_rst_wb_we", 32'(wb_we_o), 0);
        checkOutput("mid_rst_wb_addr", 32'(wb_addr_o), 0);
        checkOutput("mid_rst_wb_data", wb_data_o, 0);
        base_ack = ack_cnt;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            force_ack = (k == 0 || k == 2);
        end
        nextCycle();
        force_ack = 1'b0;
        nextCycle(); nextCycle();
        checkOutput("late_ack_count", ack_cnt - base_ack, 0);
        checkOutput("late_outstanding", 32'(dut.outstanding_q), 0);
        checkOutput("late_wb_stb", 32'(wb_stb_o), 0);
        ack_en = 1'b1;

        // Normal read after recovery
        nextCycle();
        base_ack = ack_cnt; ack_data = '0;
        applyStimulus(1'b1, 4'h0, AW'(16'h0010), '0);
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            if (m_ack_o) ack_data = m_data_o;
            if (k == 1) applyStimulus(1'b0, 4'h0, '0, '0);
        end
        nextCycle();
        checkOutput("recover_ack_data", ack_data, 32'hDEADBEEF);
        checkOutput("recover_ack_count", ack_cnt - base_ack, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
